// File: rtl/ahb_slave_responder_pkg.sv
// Shared AHB definitions used by the slave responder and its environment.
package ahb_pkg_hdl;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } ahb_slv_state_t;

endpackage

// File: rtl/ahb_slave_responder_if.sv
// AHB bus bundle: 32-bit address, 16-bit data path.
interface ahb_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [15:0] hwdata;
  logic        hready;
  logic [15:0] hrdata;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/ahb_slave_responder_regfile.sv
// DEPTH x 16 word store: one synchronous write port, one combinational read port.
module ahb_slave_regfile #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [15:0]   wdata,
  input  logic [IW-1:0] ridx,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB single-transfer slave with programmable wait states and two-cycle ERROR for out-of-range addresses.
module ahb_slave_responder
  import ahb_pkg_hdl::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          WDATA_EARLY = 1'b1
) (
  input logic  hclk,
  input logic  hreset,
  ahb_if.slave bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  // 33 bits so BASE_ADDR + 2*DEPTH cannot wrap at the top of the address map
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(2 * DEPTH);

  ahb_slv_state_t state;
  logic [3:0]     cnt;
  logic           p_write;
  logic [IW-1:0]  p_idx;
  logic [15:0]    p_wdata;
  logic           hready_q;
  logic [1:0]     hresp_q;

  logic [31:0]    offset;
  logic [IW-1:0]  a_idx;
  logic           a_err;
  logic           accept;
  logic           we;
  logic [15:0]    wdata;
  logic [15:0]    rdata;
  logic           unused_ok;

  assign offset = bus.haddr - BASE_ADDR;
  assign a_idx  = offset[IW:1];
  assign a_err  = (bus.haddr < BASE_ADDR) || ({1'b0, bus.haddr} >= LIMIT);
  assign accept = bus.hsel && bus.htrans[1] && hready_q;
  assign we     = (state == DATA) && (cnt == '0) && p_write;
  assign wdata  = WDATA_EARLY ? p_wdata : bus.hwdata;

  assign unused_ok = ^{bus.hsize, bus.hburst, bus.htrans[0], offset[31:IW+1], offset[0]};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      cnt      <= '0;
      p_write  <= 1'b0;
      p_idx    <= '0;
      p_wdata  <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else if (accept) begin
      // Accept is only possible in IDLE, ERR2 or the final DATA cycle, so it overrides them all
      p_write <= bus.hwrite;
      p_idx   <= a_idx;
      p_wdata <= bus.hwdata;
      if (a_err) begin
        state    <= ERR1;
        hready_q <= 1'b0;
        hresp_q  <= HRESP_ERROR;
      end else begin
        state    <= DATA;
        cnt      <= 4'(WAIT_STATES);
        hready_q <= (WAIT_STATES == 0);
        hresp_q  <= HRESP_OKAY;
      end
    end else begin
      case (state)
        DATA: begin
          if (cnt != '0) begin
            cnt      <= cnt - 4'd1;
            hready_q <= (cnt == 4'd1);
          end else begin
            state    <= IDLE;
            hready_q <= 1'b1;
          end
          hresp_q <= HRESP_OKAY;
        end
        ERR1: begin
          state    <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        ERR2: begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
        default: begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  ahb_slave_regfile #(.DEPTH(DEPTH)) u_regfile (
    .hclk  (hclk),
    .hreset(hreset),
    .we    (we),
    .widx  (p_idx),
    .wdata (wdata),
    .ridx  (p_idx),
    .rdata (rdata)
  );

  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = ((state == DATA) && !p_write) ? rdata : '0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Directed bench: dut0 has no wait states with early write data, dut3 has 3 wait states with data-phase write data.
module tb_ahb_slave_responder;
  import ahb_pkg_hdl::*;

  logic hclk;
  logic hreset;
  int   checks;
  int   errors;

  ahb_if a0 ();
  ahb_if a3 ();

  ahb_slave_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH      (16),
    .WAIT_STATES(0),
    .WDATA_EARLY(1'b1)
  ) dut0 (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (a0)
  );

  ahb_slave_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH      (16),
    .WAIT_STATES(3),
    .WDATA_EARLY(1'b0)
  ) dut3 (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (a3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle0;
    a0.hsel = 1'b0; a0.htrans = HTRANS_IDLE; a0.hwrite = 1'b0;
    a0.haddr = '0; a0.hwdata = '0; a0.hsize = 3'b001; a0.hburst = 3'b000;
  endtask

  task automatic idle3;
    a3.hsel = 1'b0; a3.htrans = HTRANS_IDLE; a3.hwrite = 1'b0;
    a3.haddr = '0; a3.hwdata = '0; a3.hsize = 3'b001; a3.hburst = 3'b000;
  endtask

  task automatic addr0(input logic [31:0] a, input logic w, input logic [15:0] d);
    a0.hsel = 1'b1; a0.htrans = HTRANS_NONSEQ; a0.haddr = a; a0.hwrite = w; a0.hwdata = d;
  endtask

  task automatic addr3(input logic [31:0] a, input logic w, input logic [15:0] d);
    a3.hsel = 1'b1; a3.htrans = HTRANS_NONSEQ; a3.haddr = a; a3.hwrite = w; a3.hwdata = d;
  endtask

  task automatic wait_ready3(output int lows);
    lows = 0;
    for (int i = 0; i < 10 && a3.hready !== 1'b1; i++) begin
      lows++;
      tick();
    end
  endtask

  task automatic test_reset;
    idle0(); idle3();
    hreset = 1'b1;
    tick(); tick();
    checks++; if (a0.hready !== 1'b1) begin errors++; $display("FAIL reset_hready0: got %b exp 1", a0.hready); end
    checks++; if (a0.hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp0: got %b exp 00", a0.hresp); end
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL reset_hrdata0: got %h exp 0000", a0.hrdata); end
    checks++; if (a3.hready !== 1'b1) begin errors++; $display("FAIL reset_hready3: got %b exp 1", a3.hready); end
    checks++; if (a3.hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp3: got %b exp 00", a3.hresp); end
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_write_read;
    addr0(32'h4, 1'b1, 16'hA5A5);
    tick();
    checks++; if (a0.hready !== 1'b1) begin errors++; $display("FAIL wr_hready: got %b exp 1", a0.hready); end
    addr0(32'h4, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'hA5A5) begin errors++; $display("FAIL rd_data: got %h exp a5a5", a0.hrdata); end
    checks++; if (a0.hresp !== 2'b00) begin errors++; $display("FAIL rd_hresp: got %b exp 00", a0.hresp); end
    checks++; if (a0.hready !== 1'b1) begin errors++; $display("FAIL rd_hready: got %b exp 1", a0.hready); end
    idle0();
    tick();
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL idle_hrdata: got %h exp 0000", a0.hrdata); end
  endtask

  task automatic test_back_to_back;
    addr0(32'h2, 1'b1, 16'h1234);
    tick();
    addr0(32'h2, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'h1234) begin errors++; $display("FAIL b2b_data: got %h exp 1234", a0.hrdata); end
    checks++; if (a0.hready !== 1'b1) begin errors++; $display("FAIL b2b_hready: got %b exp 1", a0.hready); end
    idle0();
    tick();
  endtask

  task automatic test_wait_states;
    int lows;
    addr3(32'h0, 1'b0, 16'h0000);
    tick();
    idle3();
    wait_ready3(lows);
    checks++; if (lows != 3) begin errors++; $display("FAIL ws_low_cycles: got %0d exp 3", lows); end
    checks++; if (a3.hrdata !== 16'h0000) begin errors++; $display("FAIL ws_hrdata: got %h exp 0000", a3.hrdata); end
    checks++; if (a3.hresp !== 2'b00) begin errors++; $display("FAIL ws_hresp: got %b exp 00", a3.hresp); end
    tick();
    checks++; if (a3.hready !== 1'b1) begin errors++; $display("FAIL ws_idle_hready: got %b exp 1", a3.hready); end
  endtask

  task automatic test_wdata_late;
    int lows;
    addr3(32'h1E, 1'b1, 16'h0000);
    tick();
    addr3(32'h1E, 1'b0, 16'hC3C3);
    wait_ready3(lows);
    checks++; if (lows != 3) begin errors++; $display("FAIL late_wr_low_cycles: got %0d exp 3", lows); end
    tick();
    idle3();
    wait_ready3(lows);
    checks++; if (a3.hrdata !== 16'hC3C3) begin errors++; $display("FAIL late_rd_data: got %h exp c3c3", a3.hrdata); end
    tick();
  endtask

  task automatic test_error;
    addr0(32'h40, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hready !== 1'b0 || a0.hresp !== 2'b01) begin errors++; $display("FAIL err1: got hready=%b hresp=%b exp 0/01", a0.hready, a0.hresp); end
    idle0();
    tick();
    checks++; if (a0.hready !== 1'b1 || a0.hresp !== 2'b01) begin errors++; $display("FAIL err2: got hready=%b hresp=%b exp 1/01", a0.hready, a0.hresp); end
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL err2_hrdata: got %h exp 0000", a0.hrdata); end
    tick();
    checks++; if (a0.hready !== 1'b1 || a0.hresp !== 2'b00) begin errors++; $display("FAIL err_idle: got hready=%b hresp=%b exp 1/00", a0.hready, a0.hresp); end
    addr0(32'h20, 1'b1, 16'hBEEF);
    tick();
    idle0();
    tick(); tick();
    addr0(32'h0, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL err_mem0: got %h exp 0000", a0.hrdata); end
    addr0(32'h4, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'hA5A5) begin errors++; $display("FAIL err_mem2: got %h exp a5a5", a0.hrdata); end
    idle0();
    tick();
  endtask

  task automatic test_reset_mid;
    int lows;
    addr3(32'h6, 1'b1, 16'h0000);
    tick();
    idle3();
    a3.hwdata = 16'hDEAD;
    tick();
    checks++; if (a3.hready !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got %b exp 0", a3.hready); end
    hreset = 1'b1;
    #1;
    checks++; if (a3.hready !== 1'b1 || a3.hresp !== 2'b00) begin errors++; $display("FAIL rst_mid_out: got hready=%b hresp=%b exp 1/00", a3.hready, a3.hresp); end
    #2;
    hreset = 1'b0;
    a3.hwdata = 16'h0000;
    tick();
    addr3(32'h6, 1'b0, 16'h0000);
    tick();
    idle3();
    wait_ready3(lows);
    checks++; if (a3.hrdata !== 16'h0000) begin errors++; $display("FAIL rst_mid_mem: got %h exp 0000", a3.hrdata); end
    tick();
    addr0(32'h4, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL rst_clear0: got %h exp 0000", a0.hrdata); end
    idle0();
    tick();
  endtask

  task automatic test_idle_busy;
    a0.hsel = 1'b1; a0.htrans = HTRANS_IDLE; a0.hwrite = 1'b1;
    a0.haddr = 32'h8; a0.hwdata = 16'hFFFF;
    tick();
    checks++; if (a0.hready !== 1'b1 || a0.hresp !== 2'b00) begin errors++; $display("FAIL htrans_idle: got hready=%b hresp=%b exp 1/00", a0.hready, a0.hresp); end
    a0.htrans = HTRANS_BUSY;
    tick();
    checks++; if (a0.hready !== 1'b1 || a0.hresp !== 2'b00) begin errors++; $display("FAIL htrans_busy: got hready=%b hresp=%b exp 1/00", a0.hready, a0.hresp); end
    a0.hsel = 1'b0; a0.htrans = HTRANS_NONSEQ;
    tick();
    checks++; if (a0.hready !== 1'b1 || a0.hresp !== 2'b00) begin errors++; $display("FAIL hsel_low: got hready=%b hresp=%b exp 1/00", a0.hready, a0.hresp); end
    addr0(32'h8, 1'b0, 16'h0000);
    tick();
    checks++; if (a0.hrdata !== 16'h0000) begin errors++; $display("FAIL nowrite_mem4: got %h exp 0000", a0.hrdata); end
    idle0();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hreset = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_wdata_late();
    test_error();
    test_reset_mid();
    test_idle_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
